arb_4x2_rr: RTL and testbench

Four-requester round-robin arbiter built around the 4-to-2 encoding function. It grants one of four requesters, holds the grant while the winner keeps requesting, and rotates priority fairly. It publishes the grant both one-hot and as a 2-bit encoded index. It sits in front of any shared single-port resource, such as a bus, memory port or encoder datapath, that four clients contend for.

---
 rtl/arb_4x2_rr_if.sv | 10 +
 rtl/arb_4x2_rr.sv | 76 +++++++
 tb/tb_arb_4x2_rr.sv | 106 ++++++++++
 3 files changed

// File: rtl/arb_4x2_rr_if.sv
// arb_4x2_rr_if: request/grant bundle between four clients and the round-robin arbiter
interface arb_4x2_rr_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       expire;
  modport master (output req, input gnt, gnt_idx, gnt_vld, expire);
  modport slave (input req, output gnt, gnt_idx, gnt_vld, expire);
endinterface

// File: rtl/arb_4x2_rr.sv
// arb_4x2_rr: 4-client round-robin arbiter with one-hot and encoded grant; ARB_HOLD_LIMIT_EN adds a hold limit
module arb_4x2_rr #(
  parameter int MAX_HOLD = 8
) (
  input logic clk,
  input logic rst,
  arb_4x2_rr_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, GRANT = 2'b01} state_t;
  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_hold
    $error("MAX_HOLD must be in 2..256");
  end
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, win, gnt_idx, idx_n;
  logic [3:0] gnt, gnt_n;
  logic gnt_vld, vld_n, found, hold, fire, arb, keep, take;
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      c = p + k[1:0];
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction
`ifdef ARB_HOLD_LIMIT_EN
  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] LIM = CW'(MAX_HOLD - 1);
  logic [CW-1:0] cnt, cnt_n;
  logic expire;
  assign fire = hold && cnt == LIM;
  // hold counter and rotation pulse for the current winner
  always_ff @(posedge clk) begin
    cnt <= rst ? '0 : cnt_n;
    expire <= rst ? 1'b0 : fire;
  end
  assign cnt_n = take ? '0 : keep ? cnt + CW'(1) : '0;
  assign bus.expire = expire;
`else
  assign fire = 1'b0;
  assign bus.expire = 1'b0;
`endif
  // next-state, pointer and grant decision; the search starts after the last winner
  always_comb begin
    {found, win} = pick(bus.req, ptr);
    hold = state == GRANT && bus.req[ptr];
    keep = hold && !fire;
    arb = state == IDLE || (state == GRANT && (!bus.req[ptr] || fire));
    take = arb && found;
    state_n = (take || keep) ? GRANT : IDLE;
    gnt_n = take ? 4'b0001 << win : keep ? gnt : 4'b0000;
    idx_n = take ? win : keep ? gnt_idx : 2'd0;
    vld_n = take || keep;
    ptr_n = take ? win : ptr;
  end
  // state, pointer and registered grant outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= 2'd3;
      gnt <= 4'b0000;
      gnt_idx <= 2'd0;
      gnt_vld <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      gnt <= gnt_n;
      gnt_idx <= idx_n;
      gnt_vld <= vld_n;
    end
  end
  assign bus.gnt = gnt;
  assign bus.gnt_idx = gnt_idx;
  assign bus.gnt_vld = gnt_vld;
endmodule

// File: tb/tb_arb_4x2_rr.sv
// tb_arb_4x2_rr: directed self-checking bench for the round-robin arbiter
module tb_arb_4x2_rr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;
  arb_4x2_rr_if bus ();
  arb_4x2_rr #(.MAX_HOLD(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] i, input logic e);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(g));
    chk({tag, "_idx"}, 32'(bus.gnt_idx), 32'(i));
    chk({tag, "_vld"}, 32'(bus.gnt_vld), 32'(g != 4'b0000));
    chk({tag, "_exp"}, 32'(bus.expire), 32'(e));
  endtask
  task automatic do_reset;
    rst = 1'b1;
    bus.req = 4'b0000;
    step;
    rst = 1'b0;
  endtask
  function automatic logic [1:0] enc(input logic [3:0] g);
    return g == 4'b0010 ? 2'd1 : g == 4'b0100 ? 2'd2 : g == 4'b1000 ? 2'd3 : 2'd0;
  endfunction
  initial begin
    logic [3:0] prev, e, eg;
    logic ee;
    bus.req = 4'b0000;
    step;
    step;
    expect_out("reset", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    bus.req = 4'b0100;
    step;
    expect_out("single", 4'b0100, 2'd2, 1'b0);
    bus.req = 4'b0000;
    step;
    expect_out("release_idle", 4'b0000, 2'd0, 1'b0);
    do_reset;
    bus.req = 4'b1111;
    step;
    expect_out("rr0", 4'b0001, 2'd0, 1'b0);
    prev = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      e = 4'b0001 << (k % 4);
      bus.req = ~prev;
      step;
      expect_out($sformatf("rr%0d", k), e, 2'(k % 4), 1'b0);
      prev = e;
    end
    do_reset;
    bus.req = 4'b0011;
    for (int c = 1; c <= 20; c++) begin
      step;
`ifdef ARB_HOLD_LIMIT_EN
      eg = (((c - 1) / 4) % 2) != 0 ? 4'b0010 : 4'b0001;
      ee = c > 1 && (c - 1) % 4 == 0;
`else
      eg = 4'b0001;
      ee = 1'b0;
`endif
      expect_out($sformatf("hold%0d", c), eg, enc(eg), ee);
    end
`ifdef ARB_HOLD_LIMIT_EN
    do_reset;
    bus.req = 4'b0001;
    for (int c = 1; c <= 12; c++) begin
      step;
      expect_out($sformatf("solo%0d", c), 4'b0001, 2'd0, c > 1 && (c - 1) % 4 == 0);
    end
`endif
    do_reset;
    bus.req = 4'b1000;
    step;
    expect_out("mid_pre", 4'b1000, 2'd3, 1'b0);
    bus.req = 4'b1001;
    rst = 1'b1;
    step;
    expect_out("mid_rst", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    step;
    expect_out("mid_post", 4'b0001, 2'd0, 1'b0);
    do_reset;
    for (int v = 0; v < 16; v++) begin
      for (int c = 0; c < 10; c++) begin
        bus.req = c == 5 ? 4'(v) & ~bus.gnt : 4'(v);
        step;
        chk("sweep_onehot", 32'($onehot0(bus.gnt)), 32'd1);
        chk("sweep_idx", 32'(bus.gnt_idx), 32'(enc(bus.gnt)));
        chk("sweep_vld", 32'(bus.gnt_vld), 32'(|bus.gnt));
        chk("sweep_subset", 32'(bus.gnt & ~bus.req), 32'd0);
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
